// File: rtl/req_encoder_16to4.sv
// req_encoder_16to4: registered 16-to-4 priority encoder with a pending-request
// mask and a valid/ready output handshake. Requests are latched into pend and
// served one at a time in priority order. A presented code is held until the
// consumer accepts it. A request that arrives while its bit is already pending
// produces a one-cycle lost pulse.
module req_encoder_16to4 #(
  parameter int LOW_FIRST = 1  // 1: bit 0 highest priority, 0: bit 15 highest
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  code,
  output logic [15:0] pend,
  output logic        lost
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  code_q,  code_d;
  logic        valid_q, valid_d;
  logic [15:0] pend_q,  pend_d;
  logic        lost_q,  lost_d;

  logic [15:0] req_en_s;  // requests admitted this cycle
  logic [15:0] cand_s;    // everything eligible for the next grant
  logic        hs_s;      // handshake completes at the coming edge
  logic [15:0] clr_s;     // pending bit retired by the handshake

  // Index of the winning set bit; the loop order makes the preferred end win.
  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    if (LOW_FIRST != 0) begin
      for (int i = 15; i >= 0; i--) begin
        idx = v[i] ? 4'(i) : idx;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        idx = v[i] ? 4'(i) : idx;
      end
    end
    return idx;
  endfunction

  // 4-to-16 one-hot decode of a code.
  function automatic logic [15:0] onehot16(input logic [3:0] c);
    return 16'd1 << c;
  endfunction

  // Pending-mask update, lost detection and grant/handshake next-state logic.
  always_comb begin
    req_en_s = en ? req : 16'd0;
    cand_s   = pend_q | req_en_s;
    hs_s     = valid_q & ready;
    clr_s    = hs_s ? onehot16(code_q) : 16'd0;
    // A request re-asserted in the handshake cycle keeps its pending bit.
    pend_d   = (pend_q & ~clr_s) | req_en_s;
    lost_d   = |(req_en_s & pend_q & ~clr_s);
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand_s) begin
          state_d = ST_GRANT;
          code_d  = prio_idx(cand_s);
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // No pre-emption: the presented code stays until it is accepted.
        // code_d keeps its value so code stays stable after valid drops.
        if (hs_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, code, pend and lost registers; reset discards any grant or request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      pend_q  <= 16'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
    end
  end

  assign valid = valid_q;
  assign code  = code_q;
  assign pend  = pend_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_req_encoder_16to4.sv
// Bench for req_encoder_16to4: drives two instances (LOW_FIRST=1 and 0) with
// the same directed stimulus. Expected codes are queued per instance when the
// stimulus is issued. Monitors pop a queue entry at every accepted handshake.
module tb_req_encoder_16to4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = 16'd0;
  logic        ready = 1'b0;

  logic        valid_lo, valid_hi, lost_lo, lost_hi;
  logic [3:0]  code_lo, code_hi;
  logic [15:0] pend_lo, pend_hi;

  int checks = 0;
  int errors = 0;
  int unsigned q_lo[$];
  int unsigned q_hi[$];

  req_encoder_16to4 #(.LOW_FIRST(1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .valid(valid_lo), .code(code_lo), .pend(pend_lo), .lost(lost_lo)
  );

  req_encoder_16to4 #(.LOW_FIRST(0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .valid(valid_hi), .code(code_hi), .pend(pend_hi), .lost(lost_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_both_idle(input string name);
    chk({name, "_valid_lo"}, 32'(valid_lo), 32'd0);
    chk({name, "_valid_hi"}, 32'(valid_hi), 32'd0);
    chk({name, "_pend_lo"},  32'(pend_lo),  32'd0);
    chk({name, "_pend_hi"},  32'(pend_hi),  32'd0);
    chk({name, "_lost_lo"},  32'(lost_lo),  32'd0);
    chk({name, "_lost_hi"},  32'(lost_hi),  32'd0);
  endtask

  task automatic push_both(input int unsigned c_lo, input int unsigned c_hi);
    q_lo.push_back(c_lo);
    q_hi.push_back(c_hi);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor for the low-first instance.
  always @(negedge clk) begin
    if (rst_n && valid_lo && ready) begin
      if (q_lo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lo_unexpected_grant: got code %0d expected none at %0t", code_lo, $time);
      end else begin
        chk("lo_code", 32'(code_lo), 32'(q_lo.pop_front()));
      end
    end
  end

  // Scoreboard monitor for the high-first instance.
  always @(negedge clk) begin
    if (rst_n && valid_hi && ready) begin
      if (q_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hi_unexpected_grant: got code %0d expected none at %0t", code_hi, $time);
      end else begin
        chk("hi_code", 32'(code_hi), 32'(q_hi.pop_front()));
      end
    end
  end

  initial begin
    // Reset state.
    #2;
    chk_both_idle("reset");
    chk("reset_code_lo", 32'(code_lo), 32'd0);
    chk("reset_code_hi", 32'(code_hi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // No requests: nothing happens for 5 cycles.
    en = 1'b1;
    ready = 1'b1;
    req = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_both_idle("idle_run");
    end

    // en=0 blocks capture.
    en = 1'b0;
    req = 16'hFFFF;
    step(1);
    req = 16'h0000;
    @(negedge clk);
    chk_both_idle("en_off");
    en = 1'b1;
    step(1);

    // 16'h8011 for one cycle with ready held: one grant every two cycles.
    push_both(0, 15);
    push_both(4, 4);
    push_both(15, 0);
    req = 16'h8011;
    step(1);
    req = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("seq_valid_lo_%0d", k), 32'(valid_lo), (k % 2 == 0 && k < 5) ? 32'd1 : 32'd0);
      chk($sformatf("seq_valid_hi_%0d", k), 32'(valid_hi), (k % 2 == 0 && k < 5) ? 32'd1 : 32'd0);
    end
    chk("seq_pend_lo", 32'(pend_lo), 32'd0);
    chk("seq_pend_hi", 32'(pend_hi), 32'd0);
    step(1);

    // No pre-emption: code 3 held while ready is low, then code 0.
    ready = 1'b0;
    push_both(3, 3);
    push_both(0, 0);
    req = 16'h0008;
    step(1);
    req = 16'h0001;
    step(1);
    req = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_code_lo", 32'(code_lo), 32'd3);
      chk("hold_code_hi", 32'(code_hi), 32'd3);
      chk("hold_valid_lo", 32'(valid_lo), 32'd1);
      chk("hold_valid_hi", 32'(valid_hi), 32'd1);
    end
    chk("hold_pend_lo", 32'(pend_lo), 32'h0009);
    step(1);
    ready = 1'b1;
    step(5);
    chk("hold_drain_pend", 32'(pend_lo), 32'd0);

    // lost pulse on re-request, and set wins over clear at handshake.
    ready = 1'b0;
    push_both(5, 5);
    req = 16'h0020;
    step(2);
    req = 16'h0000;
    @(negedge clk);
    chk("lost_pulse_lo", 32'(lost_lo), 32'd1);
    chk("lost_pulse_hi", 32'(lost_hi), 32'd1);
    step(1);
    @(negedge clk);
    chk("lost_clear_lo", 32'(lost_lo), 32'd0);
    chk("lost_clear_hi", 32'(lost_hi), 32'd0);
    step(1);
    ready = 1'b1;
    req = 16'h0020;
    push_both(5, 5);
    step(1);
    req = 16'h0000;
    @(negedge clk);
    chk("setwin_pend_lo", 32'(pend_lo), 32'h0020);
    chk("setwin_pend_hi", 32'(pend_hi), 32'h0020);
    chk("setwin_lost_lo", 32'(lost_lo), 32'd0);
    chk("setwin_valid_lo", 32'(valid_lo), 32'd0);
    step(4);
    chk("setwin_drain_pend", 32'(pend_lo), 32'd0);

    // Asynchronous reset mid-grant discards everything.
    ready = 1'b0;
    req = 16'h00F0;
    step(1);
    req = 16'h0000;
    @(negedge clk);
    chk("pre_rst_pend_lo", 32'(pend_lo), 32'h00F0);
    chk("pre_rst_code_lo", 32'(code_lo), 32'd4);
    chk("pre_rst_code_hi", 32'(code_hi), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both_idle("async_rst");
    chk("async_rst_code_lo", 32'(code_lo), 32'd0);
    chk("async_rst_code_hi", 32'(code_hi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_both_idle("post_rst");
    end

    // First request after reset is granted with single-cycle latency.
    push_both(1, 1);
    req = 16'h0002;
    step(1);
    req = 16'h0000;
    @(negedge clk);
    chk("post_rst_latency_lo", 32'(valid_lo), 32'd1);
    chk("post_rst_latency_hi", 32'(valid_hi), 32'd1);
    step(4);

    // Every queued grant must have been observed.
    chk("q_lo_empty", 32'(q_lo.size()), 32'd0);
    chk("q_hi_empty", 32'(q_hi.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
